// File: rtl/id_inst_queue.sv
// ============================================================================
// id_inst_queue
//
// Instruction queue between the I-cache return path and the ID decode
// register. Returns from the cache are accepted whenever the queue has room.
// They are not held back because ID is stalled. The ID register refills from
// the queue head. When the queue is empty, it refills directly from the
// incoming return (bypass, one cycle from cache to ID).
//
// There are two flush modes:
//   ID_clear          full flush. The queue empties and the ID register
//                     returns to its reset contents.
//   ID_clear_keep_ds  branch flush. The ID register (the branch) is kept,
//                     and only the oldest queued entry (the delay slot)
//                     survives.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   IF_pc              PC of the instruction returned by the cache
//   IF_delay_slot      returned instruction is a delay slot
//   Cache_inst         returned instruction
//   Cache_inst_valid   cache return valid
//   Cache_inst_ack     queue accepts the return this cycle (combinational)
//   ID_stall           ID holds its current instruction
//   ID_clear           full flush
//   ID_clear_keep_ds   branch flush that keeps the oldest queued entry
//   ID_pc/ID_inst/ID_delay_slot/ID_valid   registered ID stage contents
//   Q_count            queue occupancy, not counting the ID register
// ============================================================================
module id_inst_queue #(
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        PC_W     = 32,
    parameter logic [PC_W-1:0]    PC_RESET = 32'hbfc00000,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h00000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PC_W-1:0]              IF_pc,
    input  logic                         IF_delay_slot,
    input  logic [INST_W-1:0]            Cache_inst,
    input  logic                         Cache_inst_valid,
    output logic                         Cache_inst_ack,
    input  logic                         ID_stall,
    input  logic                         ID_clear,
    input  logic                         ID_clear_keep_ds,
    output logic [PC_W-1:0]              ID_pc,
    output logic [INST_W-1:0]            ID_inst,
    output logic                         ID_delay_slot,
    output logic                         ID_valid,
    output logic [$clog2(DEPTH+1)-1:0]   Q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    // Queue storage. It is not reset because the pointers and count define
    // which entries are valid.
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic              mem_ds   [DEPTH];

    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;

    logic [PW-1:0]     head_n, tail_n;
    logic [CW-1:0]     count_n;
    logic [PC_W-1:0]   pc_n;
    logic [INST_W-1:0] inst_n;
    logic              ds_n;
    logic              valid_n;

    logic              ack;
    logic              enq;
    logic              adv;
    logic              pop;
    logic              bypass;
    logic              wr;
    logic [CW-1:0]     eff_count;
    logic [PW-1:0]     tail_base;

    // The full test uses only the registered count, so a dequeue in the same
    // cycle never opens a slot for a return. This keeps ID_stall out of the
    // combinational ack path.
    always_comb begin
        ack = !reset && !ID_clear && !ID_clear_keep_ds && (count < CW'(DEPTH));
        enq = Cache_inst_valid && ack;
        adv = !ID_stall || !ID_valid;
    end

    assign Cache_inst_ack = ack;
    assign Q_count        = count;

    // Next-state logic for the pointers and the ID register.
    always_comb begin
        head_n    = head;
        tail_n    = tail;
        count_n   = count;
        pc_n      = ID_pc;
        inst_n    = ID_inst;
        ds_n      = ID_delay_slot;
        valid_n   = ID_valid;
        pop       = 1'b0;
        bypass    = 1'b0;
        wr        = 1'b0;
        eff_count = count;
        tail_base = tail;

        if (ID_clear) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
            pc_n    = PC_RESET;
            inst_n  = NOP_INST;
            ds_n    = 1'b0;
            valid_n = 1'b0;
        end else begin
            // A branch flush first truncates the queue to its head entry.
            // The normal refill rules then operate on that reduced
            // occupancy, so the surviving delay slot can pop in the same
            // cycle.
            if (ID_clear_keep_ds && (count != '0)) begin
                eff_count = CW'(1);
                tail_base = head + PW'(1);
            end

            pop    = adv && (eff_count != '0);
            bypass = adv && (eff_count == '0) && enq;
            wr     = enq && !bypass;

            if (adv) begin
                if (pop) begin
                    pc_n    = mem_pc[head];
                    inst_n  = mem_inst[head];
                    ds_n    = mem_ds[head];
                    valid_n = 1'b1;
                end else if (bypass) begin
                    pc_n    = IF_pc;
                    inst_n  = Cache_inst;
                    ds_n    = IF_delay_slot;
                    valid_n = 1'b1;
                end else begin
                    // Bubble: the PC and delay-slot flag keep their last
                    // values. Only the instruction is forced to a NOP.
                    inst_n  = NOP_INST;
                    valid_n = 1'b0;
                end
            end

            head_n  = pop ? head + PW'(1) : head;
            tail_n  = wr ? tail_base + PW'(1) : tail_base;
            count_n = eff_count + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ID_pc         <= PC_RESET;
            ID_inst       <= NOP_INST;
            ID_delay_slot <= 1'b0;
            ID_valid      <= 1'b0;
        end else begin
            head          <= head_n;
            tail          <= tail_n;
            count         <= count_n;
            ID_pc         <= pc_n;
            ID_inst       <= inst_n;
            ID_delay_slot <= ds_n;
            ID_valid      <= valid_n;
        end
    end

    // Writes occur only for accepted returns. An accepted return implies
    // that no flush is active, so the tail pointer is the write slot.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_pc[tail]   <= IF_pc;
            mem_inst[tail] <= Cache_inst;
            mem_ds[tail]   <= IF_delay_slot;
        end
    end

endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised successor to the ID-stage input register.
- Places a DEPTH-entry instruction queue between the I-cache return path and the ID decode register, so that fetched instructions are not dropped or held back at the cache while ID is stalled.
- Drives the registered ID_pc / ID_inst / ID_delay_slot set consumed by the decoder, plus an explicit ID_valid.
- Supports two flush modes: a full flush, and a branch flush that preserves the delay slot.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- INST_W, 32, instruction width.
- PC_W, 32, PC width.
- PC_RESET, 32'hbfc00000, value of ID_pc after reset or flush.
- NOP_INST, 32'h00000000, value of ID_inst whenever ID_valid=0 after reset or flush.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- IF_pc  in  PC_W  PC of the instruction being returned by the cache.
- IF_delay_slot  in  1  returned instruction is a delay slot.
- Cache_inst  in  INST_W  returned instruction.
- Cache_inst_valid  in  1  cache return valid.
- Cache_inst_ack  out  1  queue accepts the return this cycle; combinational.
- ID_stall  in  1  ID must hold its current instruction.
- ID_clear  in  1  full flush.
- ID_clear_keep_ds  in  1  branch flush; keeps the oldest queued entry.
- ID_pc  out  PC_W  registered ID PC.
- ID_inst  out  INST_W  registered ID instruction.
- ID_delay_slot  out  1  registered delay-slot flag.
- ID_valid  out  1  ID register holds a real instruction.
- Q_count  out  clog2(DEPTH+1)  current queue occupancy, excluding the ID register.

Behaviour:
- Reset (asynchronous, dominates everything):
  - Pointers and count go to 0.
  - ID_pc=PC_RESET, ID_inst=NOP_INST, ID_delay_slot=0, ID_valid=0.
  - Cache_inst_ack=0 while reset=1.
- Enqueue and ack:
  - Cache_inst_ack = !reset && !ID_clear && !ID_clear_keep_ds && (Q_count < DEPTH).
  - There is no combinational path from ID_stall to ack.
  - A full queue refuses the return even if a dequeue happens in the same cycle.
  - enq = Cache_inst_valid && Cache_inst_ack. The stored entry is {IF_pc, Cache_inst, IF_delay_slot}.
- Advancing the ID register:
  - adv = !ID_stall || !ID_valid. An empty or bubble ID register always refills.
- When adv is true:
  - If Q_count>0: the ID register loads the head entry, ID_valid=1, and the head pops.
  - Else if enq: bypass. The ID register loads the incoming return directly (latency 1 cycle, cache to ID) and nothing is written into the queue.
  - Otherwise: ID_valid=0, ID_inst=NOP_INST, and ID_pc/ID_delay_slot hold their values.
- When adv is false:
  - The ID register holds.
  - An accepted return is written into the queue.
- Simultaneous pop and enqueue:
  - Head advances and tail advances; count is unchanged.
  - Ordering is strict FIFO. The bypass is used only when the queue is empty.
- Pointers:
  - Widths are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count saturates neither way. Overflow or underflow is impossible by construction; the bench asserts this.
- ID_clear (priority over ID_clear_keep_ds):
  - Next cycle: queue empty, ID_valid=0, ID_pc=PC_RESET, ID_inst=NOP_INST, ID_delay_slot=0.
  - Any return in the same cycle is dropped (ack=0).
- ID_clear_keep_ds (ID_clear=0):
  - The ID register keeps ID_pc, ID_inst and ID_delay_slot unchanged; ID is the branch.
  - The ID register then obeys normal stall/adv rules using the surviving entry.
  - If Q_count>=1, only the oldest entry survives, becoming count=1. It is popped this cycle if adv is true, leaving count=0.
  - If Q_count=0, the queue stays empty.
  - Same-cycle returns are dropped.
- Flush with ID_stall=1 still empties the queue as defined above.

Test Plan:
- Reset: assert reset mid-stream with 3 entries queued -> same cycle ID_valid=0, ID_pc=32'hbfc00000, Q_count=0, Cache_inst_ack=0.
- Bypass: queue empty, ID_stall=0, return pc=0xbfc00000, inst=0x24080001 -> next edge ID_inst=0x24080001, ID_valid=1, Q_count=0.
- Fill and stall: ID_stall=1, 5 consecutive returns (DEPTH=4) -> 4 accepted, ack=0 on the 5th, Q_count=4. Then release the stall -> ID sees pc 0x..04, 0x..08, 0x..0c, 0x..10 in order, one per cycle.
- Simultaneous push and pop: count=2, ID_stall=0, a return each cycle for 6 cycles -> Q_count stays 2, FIFO order preserved across the pointer wrap.
- Full flush: count=3 plus a same-cycle return, ID_clear=1 -> next cycle Q_count=0, ID_valid=0, ID_inst=0, return not acked.
- Keep-delay-slot flush:
  - Setup: ID holds a branch at pc 0x100; queue holds 0x104 (ds=1), 0x108, 0x10c; ID_stall=1; pulse ID_clear_keep_ds.
  - Required: Q_count=1 and ID still shows 0x100.
  - Then release ID_stall -> ID_pc=0x104, ID_delay_slot=1, Q_count=0.
